// File: rtl/axis_frame_gen_pkg.sv
// ============================================================================
//  axis_frame_gen_pkg
//  Shared FSM encoding, pattern field offsets and channel helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BEAT_LSB  = 0;
    localparam int CHAN_LSB  = 16;
    localparam int FRAME_LSB = 24;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [3:0] first_set(input logic [15:0] mask);
        logic [3:0] r_idx;
        r_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) r_idx = 4'(i);
        end
        return r_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_frame_gen_chan_sel.sv
// ============================================================================
//  axis_frame_gen_chan_sel
//  Registered round-robin tdest pointer over the set bits of a channel mask.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module axis_frame_gen_chan_sel
    import axis_frame_gen_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DEST_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic                    load,
    input  logic                    advance,
    output logic [DEST_WIDTH-1:0]   chan
);

    logic [DEST_WIDTH-1:0] r_chan;
    logic [DEST_WIDTH-1:0] w_first;
    logic [DEST_WIDTH-1:0] w_above;
    logic                  w_above_found;

    assign w_first = DEST_WIDTH'(first_set(16'(mask)));

    // Lowest set bit strictly above the current channel; falls back to wrap.
    always_comb begin
        w_above       = '0;
        w_above_found = 1'b0;
        for (int j = NUM_CHANNELS - 1; j >= 0; j--) begin
            if (mask[j] && (j > int'(r_chan))) begin
                w_above       = DEST_WIDTH'(j);
                w_above_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_chan <= '0;
        end else if (load) begin
            r_chan <= w_first;
        end else if (advance) begin
            r_chan <= w_above_found ? w_above : w_first;
        end
    end

    assign chan = r_chan;

endmodule

`default_nettype wire

// File: rtl/axis_frame_gen.sv
// ============================================================================
//  axis_frame_gen
//  AXI4-Stream counter-pattern frame generator with round-robin tdest.
//  Optional: define AXIS_FRAME_GEN_TUSER_EN to add M_AXIS_tuser (frame index).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int DEST_WIDTH   = 4,
    parameter int LEN_WIDTH    = 16,
    parameter int GAP_WIDTH    = 16
) (
    input  logic                    aclk,
    input  logic                    arstn,
    input  logic                    start,
    input  logic                    stop,
    input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
    input  logic [15:0]             cfg_num_frames,
    input  logic [GAP_WIDTH-1:0]    cfg_gap,
    input  logic [NUM_CHANNELS-1:0] cfg_chan_mask,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tlast,
    output logic [DEST_WIDTH-1:0]   M_AXIS_tdest,
    output logic                    M_AXIS_tvalid,
`ifdef AXIS_FRAME_GEN_TUSER_EN
    output logic [15:0]             M_AXIS_tuser,
`endif
    input  logic                    M_AXIS_tready
);

    state_t                  r_state;
    logic                    r_launch;
    logic [LEN_WIDTH-1:0]    r_len_m1;
    logic [15:0]             r_num;
    logic [GAP_WIDTH-1:0]    r_gap;
    logic [NUM_CHANNELS-1:0] r_mask;
    logic [LEN_WIDTH-1:0]    r_beat;
    logic [15:0]             r_frame;
    logic [GAP_WIDTH-1:0]    r_gap_cnt;
    logic                    r_stop_pend;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_tvalid;
    logic                    r_tlast;

    logic                    w_hs;
    logic                    w_stop;
    logic                    w_last_frame;
    logic                    w_len_one;
    logic [LEN_WIDTH-1:0]    w_len_m1;
    logic [NUM_CHANNELS-1:0] w_sel_mask;
    logic                    w_load;
    logic                    w_advance;
    logic [DEST_WIDTH-1:0]   w_chan;
    logic [DATA_WIDTH-1:0]   w_tdata;

    assign w_hs         = r_tvalid & M_AXIS_tready;
    assign w_stop       = stop | r_stop_pend;
    assign w_last_frame = (r_num != 16'd0) && ((r_frame + 16'd1) == r_num);
    assign w_len_one    = (r_len_m1 == '0);
    assign w_len_m1     = (cfg_frame_len == '0) ? '0 : cfg_frame_len - LEN_WIDTH'(1);

    // Live mask is needed at start; afterwards only the latched copy counts.
    assign w_sel_mask   = (r_state == IDLE) ? cfg_chan_mask : r_mask;
    assign w_load       = (r_state == IDLE) && !r_launch && start;
    assign w_advance    = (r_state == SEND) && w_hs && r_tlast;

    axis_frame_gen_chan_sel #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .DEST_WIDTH   (DEST_WIDTH)
    ) u_chan_sel (
        .clk     (aclk),
        .arstn   (arstn),
        .mask    (w_sel_mask),
        .load    (w_load),
        .advance (w_advance),
        .chan    (w_chan)
    );

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= IDLE;
            r_launch    <= 1'b0;
            r_len_m1    <= '0;
            r_num       <= '0;
            r_gap       <= '0;
            r_mask      <= '0;
            r_beat      <= '0;
            r_frame     <= '0;
            r_gap_cnt   <= '0;
            r_stop_pend <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Start is registered for one cycle before the first beat.
                    if (r_launch) begin
                        r_launch <= 1'b0;
                        if (r_mask == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= SEND;
                            r_busy   <= 1'b1;
                            r_tvalid <= 1'b1;
                            r_tlast  <= w_len_one;
                        end
                    end else if (start) begin
                        r_launch    <= 1'b1;
                        r_len_m1    <= w_len_m1;
                        r_num       <= cfg_num_frames;
                        r_gap       <= cfg_gap;
                        r_mask      <= cfg_chan_mask;
                        r_beat      <= '0;
                        r_frame     <= '0;
                        r_stop_pend <= 1'b0;
                    end
                end
                SEND: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_frame <= r_frame + 16'd1;
                            r_beat  <= '0;
                            if (w_last_frame || w_stop) begin
                                r_state  <= DONE;
                                r_done   <= 1'b1;
                                r_busy   <= 1'b0;
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                            end else if (r_gap != '0) begin
                                r_state   <= GAP;
                                r_gap_cnt <= r_gap - GAP_WIDTH'(1);
                                r_tvalid  <= 1'b0;
                                r_tlast   <= 1'b0;
                            end else begin
                                r_tlast <= w_len_one;
                            end
                        end else begin
                            r_beat  <= r_beat + LEN_WIDTH'(1);
                            r_tlast <= ((r_beat + LEN_WIDTH'(1)) == r_len_m1);
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_gap_cnt == '0) begin
                        r_state  <= SEND;
                        r_tvalid <= 1'b1;
                        r_tlast  <= w_len_one;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_stop_pend <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pattern fields are pure wiring of registers, so they hold under stall.
    always_comb begin
        w_tdata                    = '0;
        w_tdata[BEAT_LSB  +: 16]   = 16'(r_beat);
        w_tdata[CHAN_LSB  +: 8]    = 8'(w_chan);
        w_tdata[FRAME_LSB +: 8]    = r_frame[7:0];
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign M_AXIS_tdata  = w_tdata;
    assign M_AXIS_tkeep  = '1;
    assign M_AXIS_tlast  = r_tlast;
    assign M_AXIS_tdest  = w_chan;
    assign M_AXIS_tvalid = r_tvalid;
`ifdef AXIS_FRAME_GEN_TUSER_EN
    assign M_AXIS_tuser  = r_frame;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_gen.sv
// ============================================================================
//  tb_axis_frame_gen
//  Directed vector table plus hand sequences for stop, mask 0 and reset.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_frame_gen;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_frame_len = '0;
    logic [15:0] cfg_num_frames = '0;
    logic [15:0] cfg_gap = '0;
    logic [3:0]  cfg_chan_mask = '0;
    logic        busy, done;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tvalid;
    logic [3:0]  tdest;
    logic        tready = 1'b1;

    axis_frame_gen dut (
        .aclk           (aclk),
        .arstn          (arstn),
        .start          (start),
        .stop           (stop),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_num_frames (cfg_num_frames),
        .cfg_gap        (cfg_gap),
        .cfg_chan_mask  (cfg_chan_mask),
        .busy           (busy),
        .done           (done),
        .M_AXIS_tdata   (tdata),
        .M_AXIS_tkeep   (tkeep),
        .M_AXIS_tlast   (tlast),
        .M_AXIS_tdest   (tdest),
        .M_AXIS_tvalid  (tvalid),
        .M_AXIS_tready  (tready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit rnd_rdy = 1'b0;
    bit skip_stab = 1'b0;

    logic [31:0] q_data[$];
    logic [3:0]  q_dest[$];
    logic        q_last[$];
    int          q_cyc[$];

    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;
    logic [3:0]  p_dest = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream monitor: records handshakes and polices AXIS stability.
    always @(negedge aclk) begin
        if (arstn && !skip_stab && p_valid && !p_ready) begin
            chk("stall_valid", tvalid, 1);
            if (tvalid) begin
                chk("stall_data", tdata, p_data);
                chk("stall_last", tlast, p_last);
                chk("stall_dest", tdest, p_dest);
            end
        end
        if (arstn && tvalid && tready) begin
            q_data.push_back(tdata);
            q_dest.push_back(tdest);
            q_last.push_back(tlast);
            q_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        p_valid = tvalid && arstn && !skip_stab;
        p_ready = tready;
        p_data  = tdata;
        p_last  = tlast;
        p_dest  = tdest;
    end

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_dest.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic set_cfg(input int len, input int frames, input int gap, input logic [3:0] mask);
        cfg_frame_len  = 16'(len);
        cfg_num_frames = 16'(frames);
        cfg_gap        = 16'(gap);
        cfg_chan_mask  = mask;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base = done_cnt;
        int k = 0;
        while (done_cnt == base && k < budget) begin tick(); k++; end
        chk("done_seen", 64'(done_cnt - base), 1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (q_data.size() < n && k < budget) begin tick(); k++; end
        chk("beats_reached", 64'(q_data.size() >= n), 1);
    endtask

    typedef struct {
        int          len;
        int          frames;
        int          gap;
        logic [3:0]  mask;
        bit          rnd;
        int          exp_beats;
        logic [31:0] dests;     // nibble f = expected tdest of frame f
        logic [31:0] last_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int s_cyc, le, f, b, d0;
        logic [3:0]  ed;
        logic [31:0] dd, ev;

        vecs[0] = '{16, 2, 250, 4'b0001, 1'b0, 32, 32'h00000000, 32'h0100000F};
        vecs[1] = '{4,  6, 0,   4'b1010, 1'b0, 24, 32'h00313131, 32'h05030003};
        vecs[2] = '{8,  3, 3,   4'b1111, 1'b1, 24, 32'h00000210, 32'h02020007};
        vecs[3] = '{0,  3, 1,   4'b0100, 1'b0, 3,  32'h00000222, 32'h02020000};
        vecs[4] = '{5,  2, 0,   4'b1001, 1'b1, 10, 32'h00000030, 32'h01030004};

        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tdest", tdest, 0);
        arstn = 1'b1;
        tick(); tick();

        for (int v = 0; v < 5; v++) begin
            clear_q();
            rnd_rdy = vecs[v].rnd;
            set_cfg(vecs[v].len, vecs[v].frames, vecs[v].gap, vecs[v].mask);
            s_cyc = cyc;
            pulse_start();
            set_cfg(99, 1, 0, 4'b1000);   // later cfg changes must not matter
            wait_done(3000);
            repeat (4) tick();
            rnd_rdy = 1'b0;
            le = (vecs[v].len == 0) ? 1 : vecs[v].len;
            chk("vec_beats", 64'(q_data.size()), 64'(vecs[v].exp_beats));
            if (q_data.size() == vecs[v].exp_beats) begin
                for (int i = 0; i < q_data.size(); i++) begin
                    f  = i / le;
                    b  = i % le;
                    dd = vecs[v].dests >> (4 * f);
                    ed = dd[3:0];
                    ev = {f[7:0], 4'h0, ed, b[15:0]};
                    chk("vec_data", q_data[i], ev);
                    chk("vec_dest", q_dest[i], ed);
                    chk("vec_last", q_last[i], (b == le - 1));
                end
                chk("vec_final_data", q_data[q_data.size()-1], vecs[v].last_data);
                chk("vec_done_lat", 64'(done_cyc - q_cyc[q_cyc.size()-1]), 1);
                if (!vecs[v].rnd) begin
                    chk("vec_start_lat", 64'(q_cyc[0] - s_cyc), 2);
                    for (int k = 1; k < vecs[v].frames; k++) begin
                        chk("vec_gap", 64'(q_cyc[k*le] - q_cyc[k*le-1]), 64'(vecs[v].gap + 1));
                        chk("vec_flen", 64'(q_cyc[k*le-1] - q_cyc[(k-1)*le]), 64'(le - 1));
                    end
                end
            end
            chk("vec_busy_low", busy, 0);
        end

        // Mask 0: done two cycles after start, no beats.
        clear_q();
        set_cfg(4, 1, 0, 4'b0000);
        pulse_start();
        chk("mask0_done_early", done, 0);
        tick();
        chk("mask0_done", done, 1);
        chk("mask0_busy", busy, 0);
        tick();
        chk("mask0_done_pulse", done, 0);
        repeat (3) tick();
        chk("mask0_beats", 64'(q_data.size()), 0);

        // Start+stop together in IDLE, then a second start while busy.
        clear_q();
        d0 = done_cnt;
        set_cfg(4, 2, 2, 4'b0001);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        set_cfg(2, 5, 0, 4'b0010);
        pulse_start();
        wait_done(200);
        repeat (6) tick();
        chk("busy_start_beats", 64'(q_data.size()), 8);
        chk("busy_start_dones", 64'(done_cnt - d0), 1);
        if (q_dest.size() > 0) chk("busy_start_dest", q_dest[q_dest.size()-1], 0);

        // Continuous mode, stop during frame 5.
        clear_q();
        set_cfg(3, 0, 2, 4'b0011);
        pulse_start();
        wait_beats(16, 500);
        pulse_stop();
        wait_done(200);
        repeat (6) tick();
        chk("stop_beats", 64'(q_data.size()), 18);
        if (q_data.size() > 0) begin
            chk("stop_last", q_last[q_last.size()-1], 1);
            chk("stop_data", q_data[q_data.size()-1], 32'h05010002);
            chk("stop_done_lat", 64'(done_cyc - q_cyc[q_cyc.size()-1]), 1);
        end

        // Stop during the inter-frame gap.
        clear_q();
        set_cfg(2, 0, 20, 4'b0001);
        pulse_start();
        wait_beats(2, 100);
        repeat (3) tick();
        pulse_stop();
        chk("gap_stop_done", done, 1);
        repeat (5) tick();
        chk("gap_stop_beats", 64'(q_data.size()), 2);

        // Reset mid-frame, then a clean restart.
        clear_q();
        set_cfg(8, 1, 0, 4'b0001);
        pulse_start();
        wait_beats(3, 100);
        skip_stab = 1'b1;
        arstn = 1'b0;
        #1;
        chk("rst_mid_tvalid", tvalid, 0);
        chk("rst_mid_tlast", tlast, 0);
        chk("rst_mid_busy", busy, 0);
        tick(); tick();
        arstn = 1'b1;
        tick();
        skip_stab = 1'b0;
        clear_q();
        set_cfg(8, 1, 0, 4'b0100);
        pulse_start();
        wait_done(200);
        repeat (3) tick();
        chk("restart_beats", 64'(q_data.size()), 8);
        if (q_data.size() > 0) begin
            chk("restart_first", q_data[0], 32'h00020000);
            chk("restart_dest", q_dest[0], 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
